memory_arbiter_rr: RTL



---
 rtl/memory_arbiter_rr.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: shares one memory port among ACCESSOR_COUNT accessors.
// Arbitration is either fixed priority (lowest index wins) or round-robin.
// A grant is held while the winner keeps requesting, while memory_ready is
// high, or while the winner holds its lock. Every release passes through one
// IDLE cycle, and re-arbitration happens in that cycle.
module memory_arbiter_rr #(
    parameter int SIZE           = 32,
    parameter int ACCESSOR_COUNT = 4,
    parameter int PRIORITY_MODE  = 1,
    localparam int INDEX_SIZE    = (ACCESSOR_COUNT > 1) ? $clog2(ACCESSOR_COUNT) : 1
) (
    input  logic                           clock,
    input  logic                           reset,

    output logic                           memory_enable,
    output logic                           memory_operation,
    input  logic                           memory_ready,
    output logic [1:0]                     memory_data_size,
    output logic [SIZE-1:0]                memory_address,
    input  logic [SIZE-1:0]                memory_data_in,
    output logic [SIZE-1:0]                memory_data_out,

    input  logic [ACCESSOR_COUNT-1:0]      accessor_memory_enable,
    input  logic [ACCESSOR_COUNT-1:0]      accessor_memory_lock,
    input  logic [ACCESSOR_COUNT-1:0]      accessor_memory_operation,
    output logic [ACCESSOR_COUNT-1:0]      accessor_memory_ready,
    input  logic [2*ACCESSOR_COUNT-1:0]    accessor_memory_data_size,
    input  logic [SIZE*ACCESSOR_COUNT-1:0] accessor_memory_address,
    output logic [SIZE*ACCESSOR_COUNT-1:0] accessor_memory_data_in,
    input  logic [SIZE*ACCESSOR_COUNT-1:0] accessor_memory_data_out,

    output logic                           grant_valid,
    output logic [INDEX_SIZE-1:0]          grant_index
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_valid_q;
    logic [INDEX_SIZE-1:0] grant_index_q, grant_index_d;
    logic [INDEX_SIZE-1:0] rr_pointer_q, rr_pointer_d;

    logic                  any_request;
    logic [INDEX_SIZE-1:0] winner;
    logic                  found_lo, found_hi;
    logic [INDEX_SIZE-1:0] lo_index, hi_index;

    logic                  sel_enable;
    logic                  sel_lock;
    logic                  sel_operation;
    logic [1:0]            sel_data_size;
    logic [SIZE-1:0]       sel_address;
    logic [SIZE-1:0]       sel_data_out;

    assign any_request = |accessor_memory_enable;

    // Pick the winner among current requests.
    // Round-robin is done as two scans instead of a modulo walk: the first
    // requester above rr_pointer wins, otherwise the lowest requester overall
    // (the wrap-around case). Same order as starting at rr_pointer+1 mod N.
    always_comb begin
        found_lo = 1'b0;
        found_hi = 1'b0;
        lo_index = '0;
        hi_index = '0;
        for (int unsigned i = 0; i < ACCESSOR_COUNT; i++) begin
            if (accessor_memory_enable[i]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_index = INDEX_SIZE'(i);
                end
                if (!found_hi && (INDEX_SIZE'(i) > rr_pointer_q)) begin
                    found_hi = 1'b1;
                    hi_index = INDEX_SIZE'(i);
                end
            end
        end
        if (PRIORITY_MODE == 0) begin
            winner = lo_index;
        end else begin
            winner = found_hi ? hi_index : lo_index;
        end
    end

    // Select the granted accessor's request signals; valid in both states.
    always_comb begin
        sel_enable    = 1'b0;
        sel_lock      = 1'b0;
        sel_operation = 1'b0;
        sel_data_size = '0;
        sel_address   = '0;
        sel_data_out  = '0;
        for (int unsigned i = 0; i < ACCESSOR_COUNT; i++) begin
            if (grant_index_q == INDEX_SIZE'(i)) begin
                sel_enable    = accessor_memory_enable[i];
                sel_lock      = accessor_memory_lock[i];
                sel_operation = accessor_memory_operation[i];
                sel_data_size = accessor_memory_data_size[2*i +: 2];
                sel_address   = accessor_memory_address[SIZE*i +: SIZE];
                sel_data_out  = accessor_memory_data_out[SIZE*i +: SIZE];
            end
        end
    end

    // Next-state decision for the grant FSM.
    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        rr_pointer_d  = rr_pointer_q;
        case (state_q)
            IDLE: begin
                if (any_request) begin
                    state_d       = GRANTED;
                    grant_index_d = winner;
                    rr_pointer_d  = winner;
                end
            end
            GRANTED: begin
                if (!sel_enable && !memory_ready && !sel_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant FSM registers; reset leaves index 0 as first round-robin preference.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            rr_pointer_q  <= INDEX_SIZE'(ACCESSOR_COUNT - 1);
        end else begin
            state_q       <= state_d;
            grant_valid_q <= (state_d == GRANTED);
            grant_index_q <= grant_index_d;
            rr_pointer_q  <= rr_pointer_d;
        end
    end

    // Per-accessor ready routing and unconditional read-data broadcast.
    for (genvar g = 0; g < ACCESSOR_COUNT; g++) begin : g_accessor
        assign accessor_memory_ready[g] = (state_q == GRANTED) &&
                                          (grant_index_q == INDEX_SIZE'(g)) &&
                                          memory_ready;
        assign accessor_memory_data_in[SIZE*g +: SIZE] = memory_data_in;
    end

    assign memory_enable    = (state_q == GRANTED) && sel_enable;
    assign memory_operation = sel_operation;
    assign memory_data_size = sel_data_size;
    assign memory_address   = sel_address;
    assign memory_data_out  = sel_data_out;

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;

endmodule
